// File: rtl/range_normalizer.sv
// range_normalizer: iterative right-shift normaliser with shift count,
// divider code, saturation and sticky-inexact reporting.
module range_normalizer #(
    parameter int WIDTH         = 40,
    parameter int HEADROOM      = 12,
    parameter int MAX_SHIFT     = 12,
    parameter int SHIFT_W       = 4,
    parameter bit CHANGE_DETECT = 1'b1
) (
    input  logic               CLK67MHZ,
    input  logic               resetPort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [SHIFT_W-1:0] out_divider,
    output logic               out_sat,
    output logic               out_inexact,
    output logic               out_valid,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHIFT_W-1:0] count_q, count_d;
    logic               sticky_q, sticky_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [SHIFT_W-1:0] div_q, div_d;
    logic               sat_q, sat_d;
    logic               inexact_q, inexact_d;
    logic               valid_q, valid_d;

    logic capture;
    logic fit;
    logic at_max;
    logic in_shift;

    assign in_shift = (state_q == SHIFT);
    assign fit      = ~|work_q[WIDTH-1 -: HEADROOM];
    assign at_max   = (count_q == MAX_S);

    // A new word is taken on any change of input, or on an accepted request.
    assign capture = CHANGE_DETECT ? (in_data != prev_q)
                                   : (!in_shift && in_valid);

    // Next-state, datapath step and completion write-back.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        data_d    = data_q;
        shift_d   = shift_q;
        div_d     = div_q;
        sat_d     = sat_q;
        inexact_d = inexact_q;
        valid_d   = 1'b0;
        priority case (1'b1)
            capture: begin
                work_d   = in_data;
                count_d  = '0;
                sticky_d = 1'b0;
                state_d  = SHIFT;
            end
            (in_shift && (fit || at_max)): begin
                data_d    = work_q;
                shift_d   = count_q;
                div_d     = MAX_S - count_q;
                sat_d     = !fit;
                inexact_d = sticky_q;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            in_shift: begin
                work_d   = work_q >> 1;
                sticky_d = sticky_q | work_q[0];
                count_d  = count_q + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Conversion state and registered result.
    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            work_q    <= '0;
            count_q   <= '0;
            sticky_q  <= 1'b0;
            data_q    <= '0;
            shift_q   <= '0;
            div_q     <= MAX_S;
            sat_q     <= 1'b0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= in_data;
            work_q    <= work_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            sat_q     <= sat_d;
            inexact_q <= inexact_d;
            valid_q   <= valid_d;
        end
    end

    assign in_ready    = resetPort && !in_shift;
    assign busy        = in_shift;
    assign out_data    = data_q;
    assign out_shift   = shift_q;
    assign out_divider = div_q;
    assign out_sat     = sat_q;
    assign out_inexact = inexact_q;
    assign out_valid   = valid_q;

endmodule

// File: tb/tb_range_normalizer.sv
// tb_range_normalizer: directed checks of range_normalizer in
// change-detect, reduced MAX_SHIFT and handshake configurations.
module tb_range_normalizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        d_iv = 1'b0, m_iv = 1'b0, h_iv = 1'b0;
    logic [39:0] d_in = '0, m_in = '0, h_in = '0;
    logic        d_rdy, m_rdy, h_rdy;
    logic [39:0] d_od, m_od, h_od;
    logic [3:0]  d_sh, m_sh, h_sh;
    logic [3:0]  d_dv, m_dv, h_dv;
    logic        d_sat, m_sat, h_sat;
    logic        d_inx, m_inx, h_inx;
    logic        d_ov, m_ov, h_ov;
    logic        d_bz, m_bz, h_bz;

    int checks = 0;
    int passed = 0;

    range_normalizer u_def (
        .CLK67MHZ(clk), .resetPort(rst_n), .in_valid(d_iv),
        .in_ready(d_rdy), .in_data(d_in), .out_data(d_od),
        .out_shift(d_sh), .out_divider(d_dv), .out_sat(d_sat),
        .out_inexact(d_inx), .out_valid(d_ov), .busy(d_bz)
    );

    range_normalizer #(.MAX_SHIFT(8)) u_m8 (
        .CLK67MHZ(clk), .resetPort(rst_n), .in_valid(m_iv),
        .in_ready(m_rdy), .in_data(m_in), .out_data(m_od),
        .out_shift(m_sh), .out_divider(m_dv), .out_sat(m_sat),
        .out_inexact(m_inx), .out_valid(m_ov), .busy(m_bz)
    );

    range_normalizer #(.CHANGE_DETECT(1'b0)) u_hs (
        .CLK67MHZ(clk), .resetPort(rst_n), .in_valid(h_iv),
        .in_ready(h_rdy), .in_data(h_in), .out_data(h_od),
        .out_shift(h_sh), .out_divider(h_dv), .out_sat(h_sat),
        .out_inexact(h_inx), .out_valid(h_ov), .busy(h_bz)
    );

    // Edges counted from stimulus until out_valid is seen; -1 on timeout.
    task automatic wait_valid(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if ((which == 0 && d_ov) || (which == 1 && m_ov) ||
                (which == 2 && h_ov)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (d_od !== 40'h0) $display("FAIL rst_data: got %h expected %h", d_od, 40'h0);
        else passed++;
        checks++;
        if (d_sh !== 4'd0) $display("FAIL rst_shift: got %0d expected 0", d_sh);
        else passed++;
        checks++;
        if (d_dv !== 4'd12) $display("FAIL rst_div: got %0d expected 12", d_dv);
        else passed++;
        checks++;
        if (m_dv !== 4'd8) $display("FAIL rst_div_m8: got %0d expected 8", m_dv);
        else passed++;
        checks++;
        if ({d_sat, d_inx, d_ov, d_bz, d_rdy} !== 5'b0)
            $display("FAIL rst_flags: got %b expected 00000", {d_sat, d_inx, d_ov, d_bz, d_rdy});
        else passed++;
        checks++;
        if (h_rdy !== 1'b0) $display("FAIL rst_ready_hs: got %b expected 0", h_rdy);
        else passed++;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({d_rdy, d_bz} !== 2'b10) $display("FAIL idle_after_rst: got %b expected 10", {d_rdy, d_bz});
        else passed++;
    endtask

    task automatic test_fit_immediate;
        int n;
        @(posedge clk); #1;
        d_in = 40'h00_0000_1234;
        wait_valid(0, 20, n);
        checks++;
        if (n !== 2) $display("FAIL fit_latency: got %0d expected 2", n);
        else passed++;
        checks++;
        if ({d_od, d_sh, d_dv, d_sat, d_inx} !== {40'h00_0000_1234, 4'd0, 4'd12, 2'b00})
            $display("FAIL fit_result: got %h/%0d/%0d/%b%b expected 0000001234/0/12/00",
                     d_od, d_sh, d_dv, d_sat, d_inx);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (d_ov !== 1'b0) $display("FAIL fit_valid_width: got %b expected 0", d_ov);
        else passed++;
    endtask

    task automatic test_full_shift;
        int n;
        @(posedge clk); #1;
        d_in = 40'h80_0000_0000;
        @(posedge clk); #1;
        checks++;
        if ({d_bz, d_rdy} !== 2'b10) $display("FAIL full_busy: got %b expected 10", {d_bz, d_rdy});
        else passed++;
        checks++;
        if (d_od !== 40'h00_0000_1234) $display("FAIL full_hold: got %h expected %h", d_od, 40'h00_0000_1234);
        else passed++;
        wait_valid(0, 30, n);
        checks++;
        if (n !== 13) $display("FAIL full_latency: got %0d expected 13", n);
        else passed++;
        checks++;
        if ({d_od, d_sh, d_dv, d_sat, d_inx} !== {40'h00_0800_0000, 4'd12, 4'd0, 2'b00})
            $display("FAIL full_result: got %h/%0d/%0d/%b%b expected 0008000000/12/0/00",
                     d_od, d_sh, d_dv, d_sat, d_inx);
        else passed++;
    endtask

    task automatic test_inexact;
        int n;
        @(posedge clk); #1;
        d_in = 40'h10_0000_0001;
        wait_valid(0, 30, n);
        checks++;
        if (n !== 11) $display("FAIL inx_latency: got %0d expected 11", n);
        else passed++;
        checks++;
        if ({d_od, d_sh, d_dv, d_sat, d_inx} !== {40'h00_0800_0000, 4'd9, 4'd3, 2'b01})
            $display("FAIL inx_result: got %h/%0d/%0d/%b%b expected 0008000000/9/3/01",
                     d_od, d_sh, d_dv, d_sat, d_inx);
        else passed++;
    endtask

    task automatic test_saturate;
        int n;
        @(posedge clk); #1;
        m_in = 40'h80_0000_0000;
        wait_valid(1, 30, n);
        checks++;
        if (n !== 10) $display("FAIL sat_latency: got %0d expected 10", n);
        else passed++;
        checks++;
        if ({m_od, m_sh, m_dv, m_sat, m_inx} !== {40'h00_8000_0000, 4'd8, 4'd0, 2'b10})
            $display("FAIL sat_result: got %h/%0d/%0d/%b%b expected 0080000000/8/0/10",
                     m_od, m_sh, m_dv, m_sat, m_inx);
        else passed++;
    endtask

    task automatic test_abort;
        int pulses = 0;
        logic [39:0] seen_d = '0;
        logic [3:0]  seen_s = '1;
        @(posedge clk); #1;
        d_in = 40'hFF_0000_0000;
        repeat (3) @(posedge clk);
        #1;
        d_in = 40'h00_0000_00FF;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (d_ov) begin
                pulses++;
                seen_d = d_od;
                seen_s = d_sh;
            end
        end
        checks++;
        if (pulses !== 1) $display("FAIL abort_pulses: got %0d expected 1", pulses);
        else passed++;
        checks++;
        if ({seen_d, seen_s} !== {40'h00_0000_00FF, 4'd0})
            $display("FAIL abort_result: got %h/%0d expected 00000000ff/0", seen_d, seen_s);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge clk); #1;
        d_in = 40'h80_0000_0000;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_od, d_sh, d_dv} !== {40'h0, 4'd0, 4'd12})
            $display("FAIL mid_rst_out: got %h/%0d/%0d expected 0000000000/0/12", d_od, d_sh, d_dv);
        else passed++;
        checks++;
        if ({d_sat, d_inx, d_ov, d_bz, d_rdy} !== 5'b0)
            $display("FAIL mid_rst_flags: got %b expected 00000", {d_sat, d_inx, d_ov, d_bz, d_rdy});
        else passed++;
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_valid(0, 30, n);
        checks++;
        if (n !== 14) $display("FAIL mid_rst_recapture: got %0d expected 14", n);
        else passed++;
        checks++;
        if ({d_od, d_sh} !== {40'h00_0800_0000, 4'd12})
            $display("FAIL mid_rst_result: got %h/%0d expected 0008000000/12", d_od, d_sh);
        else passed++;
    endtask

    task automatic test_handshake;
        int bad = 0;
        int extra = 0;
        int n = -1;
        @(posedge clk); #1;
        checks++;
        if (h_rdy !== 1'b1) $display("FAIL hs_ready_idle: got %b expected 1", h_rdy);
        else passed++;
        h_in = 40'h80_0000_0000;
        h_iv = 1'b1;
        @(posedge clk); #1;
        h_iv = 1'b0;
        checks++;
        if ({h_bz, h_rdy} !== 2'b10) $display("FAIL hs_busy: got %b expected 10", {h_bz, h_rdy});
        else passed++;
        h_in = 40'h00_0000_1234;
        h_iv = 1'b1;
        @(posedge clk); #1;
        h_iv = 1'b0;
        if (h_rdy) bad++;
        for (int i = 2; i < 30; i++) begin
            @(posedge clk); #1;
            if (h_ov) begin
                n = i;
                break;
            end
            if (h_rdy) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL hs_ready_busy: got %0d expected 0", bad);
        else passed++;
        checks++;
        if (n !== 13) $display("FAIL hs_latency: got %0d expected 13", n);
        else passed++;
        checks++;
        if ({h_od, h_sh, h_sat} !== {40'h00_0800_0000, 4'd12, 1'b0})
            $display("FAIL hs_result: got %h/%0d/%b expected 0008000000/12/0", h_od, h_sh, h_sat);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (h_ov || h_bz) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL hs_not_queued: got %0d expected 0", extra);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fit_immediate();
        test_full_shift();
        test_inexact();
        test_saturate();
        test_abort();
        test_reset_mid();
        test_handshake();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/range_normalizer.md
Name: range_normalizer

Overview:
- Parametrised iterative range normaliser; successor to the fixed 40-bit/12-bit shift-count block that feeds the clock divider and the sigma-delta modulator input.
- Right-shifts a captured word one bit per clock until its top HEADROOM bits are all zero, or until MAX_SHIFT shifts have been done.
- Reports the shifted word, the shift count, the complementary divider code, a saturation flag and an inexact (sticky) flag.
- Supports two capture modes: automatic change-detect, or explicit valid/ready handshake.

Parameters:
- WIDTH, 40, data width in bits
- HEADROOM, 12, number of MSBs that must be zero for the word to fit; legal range 1..WIDTH-1
- MAX_SHIFT, 12, maximum number of shifts; must be <= WIDTH and < 2**SHIFT_W
- SHIFT_W, 4, width of the shift-count and divider outputs
- CHANGE_DETECT, 1, 1 = capture on any input change (in_valid ignored); 0 = capture on in_valid & in_ready

Ports:
- CLK67MHZ  in  1  system clock; all state changes on its rising edge
- resetPort  in  1  asynchronous, active-low reset
- in_valid  in  1  capture request; used only when CHANGE_DETECT=0
- in_ready  out  1  block idle and able to accept
- in_data  in  WIDTH  word to normalise
- out_data  out  WIDTH  normalised word, held between updates
- out_shift  out  SHIFT_W  number of right shifts applied
- out_divider  out  SHIFT_W  MAX_SHIFT - out_shift
- out_sat  out  1  MAX_SHIFT was reached and the top HEADROOM bits were still nonzero
- out_inexact  out  1  at least one 1 bit was shifted out
- out_valid  out  1  one-cycle pulse in the cycle after the outputs update
- busy  out  1  conversion in progress

Behaviour:
- Reset (resetPort=0, asynchronous):
  - State goes to IDLE.
  - out_data=0, out_shift=0, out_divider=MAX_SHIFT, out_sat=0, out_inexact=0, out_valid=0, busy=0, in_ready=0 while reset is asserted.
  - Internal prev register=0; work register=0; count=0.
- States:
  - IDLE: busy=0; in_ready=1 while reset is deasserted.
  - SHIFT: busy=1; in_ready=0.
- Capture condition at an edge:
  - CHANGE_DETECT=1: in_data != prev, in any state.
  - CHANGE_DETECT=0: state is IDLE and in_valid=1.
- prev register: loads in_data every edge in both modes.
- On capture: work<=in_data, count<=0, sticky<=0, next state SHIFT.
  - In CHANGE_DETECT=1, a capture during SHIFT aborts the current conversion. The latest value wins, and the aborted value produces no out_valid.
- Each edge in SHIFT with no capture:
  - fit = (work[WIDTH-1 -: HEADROOM] == 0).
  - If fit, or count==MAX_SHIFT: write out_data=work, out_shift=count, out_divider=MAX_SHIFT-count, out_sat=(!fit), out_inexact=sticky. Pulse out_valid high for the next cycle. Go to IDLE.
  - Else: work<=work>>1 with zero fill; sticky<=sticky|work[0]; count<=count+1.
- Latency:
  - With capture at edge E0 and k shifts needed, the outputs update at edge E0+k+1.
  - out_valid is high for exactly one cycle, from E0+k+1 to E0+k+2.
  - Minimum latency (k=0) is 1 edge.
- Fit is checked before saturation, so a word that fits at exactly count==MAX_SHIFT gives out_sat=0.
- Outputs never change except at a completion edge or on reset; there are no partial updates.
- in_data=0 fits immediately: shift 0, inexact 0.
- CHANGE_DETECT=0: in_valid while busy is ignored, not queued.

Test Plan:
- Default params, in_data 40'h00_0000_1234 -> out_data=40'h00_0000_1234, out_shift=0, out_divider=12, out_sat=0, out_inexact=0; outputs update 1 edge after capture; out_valid is one cycle wide.
- Default params, in_data 40'h80_0000_0000 -> out_data=40'h00_0800_0000, out_shift=12, out_divider=0, out_sat=0 (fits at count==MAX_SHIFT); outputs update 13 edges after capture.
- Default params, in_data 40'h10_0000_0001 -> out_data=40'h00_0800_0000, out_shift=9, out_divider=3, out_inexact=1, out_sat=0.
- MAX_SHIFT=8, in_data 40'h80_0000_0000 -> out_data=40'h00_8000_0000, out_shift=8, out_divider=0, out_sat=1, out_inexact=0.
- CHANGE_DETECT=1: apply 40'hFF_0000_0000, then change to 40'h00_0000_00FF three cycles later -> only one out_valid pulse, with out_shift=0 and out_data=40'h00_0000_00FF; the earlier value produces no output.
- Reset and handshake:
  - Drive resetPort low mid-SHIFT -> all outputs take their reset values immediately (out_divider=12).
  - After release with in_data held nonzero, CHANGE_DETECT=1 captures at the first edge, because prev was reset to 0.
  - CHANGE_DETECT=0: in_valid pulsed while busy -> ignored, in_ready=0 throughout.
